// File: rtl/mem_wishbone_bridge.sv
// Memory-side request to Wishbone B4 master bridge.
// One request at a time: reads as incrementing bursts, writes as single beats.
module mem_wishbone_bridge #(
    parameter bit BURST_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        request,
    input  logic [29:0] addr,
    input  logic [4:0]  rlen,
    input  logic        rnw,
    input  logic        rmw,
    input  logic [3:0]  wbe,
    input  logic [31:0] wdata,
    input  logic [1:0]  id,
    output logic        ack,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic [1:0]  rid,
    output logic        inv,
    output logic [29:0] inv_addr,
    output logic        write_outstanding,
    output logic [29:0] wb_adr,
    output logic [31:0] wb_dat_w,
    output logic [3:0]  wb_sel,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [2:0]  wb_cti,
    output logic [1:0]  wb_bte,
    input  logic [31:0] wb_dat_r,
    input  logic        wb_ack,
    input  logic        wb_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  beat_cnt;
    logic [4:0]  cnt_next;
    logic [2:0]  cti_next;
    logic [1:0]  id_q;
    logic        term;
    logic        load;
    logic        rd_beat;
    logic        unused_rmw;

    // Read-modify-write hint carries no meaning for this bus.
    assign unused_rmw = rmw;

    assign term     = wb_ack | wb_err;
    assign wb_stb   = wb_cyc;
    assign wb_bte   = 2'b00;
    assign inv      = 1'b0;
    assign inv_addr = 30'd0;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, request accept and beat bookkeeping.
    always_comb begin
        state_next        = state;
        ack               = 1'b0;
        load              = 1'b0;
        rd_beat           = 1'b0;
        write_outstanding = 1'b0;
        unique case (state)
            IDLE: begin
                ack = request;
                if (request) begin
                    load       = 1'b1;
                    state_next = rnw ? READ : WRITE;
                end
            end
            READ: begin
                if (term) begin
                    rd_beat = 1'b1;
                    if (beat_cnt == 5'd0) begin
                        state_next = IDLE;
                    end
                end
            end
            WRITE: begin
                write_outstanding = 1'b1;
                if (term) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        cnt_next = beat_cnt;
        if (load) begin
            cnt_next = rlen;
        end else if (rd_beat) begin
            cnt_next = beat_cnt - 5'd1;
        end

        cti_next = 3'b000;
        if (BURST_EN) begin
            if (state_next == READ) begin
                cti_next = (cnt_next != 5'd0) ? 3'b010 : 3'b111;
            end else if (state_next == WRITE) begin
                cti_next = 3'b111;
            end
        end
    end

    // Registered Wishbone outputs, request latches and read return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_cyc   <= 1'b0;
            wb_we    <= 1'b0;
            wb_cti   <= 3'b000;
            wb_adr   <= 30'd0;
            wb_sel   <= 4'd0;
            wb_dat_w <= 32'd0;
            beat_cnt <= 5'd0;
            id_q     <= 2'd0;
            rvalid   <= 1'b0;
            rdata    <= 32'd0;
            rid      <= 2'd0;
        end else begin
            wb_cyc   <= (state_next != IDLE);
            wb_we    <= (state_next == WRITE);
            wb_cti   <= cti_next;
            beat_cnt <= cnt_next;
            rvalid   <= 1'b0;
            if (load) begin
                wb_adr   <= addr;
                wb_sel   <= rnw ? 4'hF : wbe;
                wb_dat_w <= wdata;
                id_q     <= id;
            end
            if (rd_beat) begin
                rdata  <= wb_dat_r;
                rid    <= id_q;
                rvalid <= 1'b1;
                wb_adr <= wb_adr + 30'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_wishbone_bridge.sv
// Self-checking bench for mem_wishbone_bridge.
// Randomized Wishbone slave plus transaction-level expectations.
module tb_mem_wishbone_bridge;

    localparam bit BURST_EN = 1'b1;

    typedef struct packed {
        logic [29:0] adr;
        logic [2:0]  cti;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
    } beat_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  id;
        int          cyc;
    } rv_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        request;
    logic [29:0] addr;
    logic [4:0]  rlen;
    logic        rnw;
    logic        rmw;
    logic [3:0]  wbe;
    logic [31:0] wdata;
    logic [1:0]  id;
    logic        ack;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rid;
    logic        inv;
    logic [29:0] inv_addr;
    logic        write_outstanding;
    logic [29:0] wb_adr;
    logic [31:0] wb_dat_w;
    logic [3:0]  wb_sel;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic [31:0] wb_dat_r;
    logic        wb_ack;
    logic        wb_err;

    int n_checks = 0;
    int n_fail = 0;

    beat_t beat_q[$];
    rv_t   rv_q[$];
    beat_t slv_b;
    rv_t   mon_r;
    int    cyc_cnt = 0;
    int    wo_cycles = 0;
    int    we_cycles = 0;
    int    cyc_cycles = 0;

    int          slv_wmin = 0;
    int          slv_wmax = 0;
    bit          slv_noise = 1'b0;
    int          slv_err_beat = -1;
    bit          slv_fix = 1'b0;
    logic [31:0] slv_fix_data = 32'd0;
    int          wcnt = -1;
    int          bidx = 0;

    mem_wishbone_bridge #(.BURST_EN(BURST_EN)) dut (
        .clk(clk), .rst(rst), .request(request), .addr(addr),
        .rlen(rlen), .rnw(rnw), .rmw(rmw), .wbe(wbe), .wdata(wdata),
        .id(id), .ack(ack), .rvalid(rvalid), .rdata(rdata), .rid(rid),
        .inv(inv), .inv_addr(inv_addr),
        .write_outstanding(write_outstanding),
        .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_sel(wb_sel),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_cti(wb_cti), .wb_bte(wb_bte), .wb_dat_r(wb_dat_r),
        .wb_ack(wb_ack), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {a, 2'b10} ^ 32'hC3A5_5A3C;
    endfunction

    function automatic logic [2:0] exp_rd_cti(input int k, input int l);
        if (!BURST_EN) return 3'b000;
        return (k == l) ? 3'b111 : 3'b010;
    endfunction

    // Cycle counter used to time-stamp read returns.
    always @(posedge clk) cyc_cnt++;

    // Wishbone slave: random wait states, optional noise acks and error beat.
    always @(negedge clk) begin
        if (rst || !wb_cyc || !wb_stb) begin
            wb_err   = 1'b0;
            wb_ack   = slv_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            wb_dat_r = $urandom;
            wcnt     = -1;
            if (!wb_cyc) bidx = 0;
        end else begin
            if (wcnt < 0) wcnt = $urandom_range(slv_wmax, slv_wmin);
            if (wcnt == 0) begin
                if (bidx == slv_err_beat) begin
                    wb_err   = 1'b1;
                    wb_ack   = 1'b0;
                    wb_dat_r = 32'd0;
                end else begin
                    wb_err   = 1'b0;
                    wb_ack   = 1'b1;
                    wb_dat_r = slv_fix ? slv_fix_data : mem_word(wb_adr);
                end
                slv_b.adr = wb_adr;
                slv_b.cti = wb_cti;
                slv_b.we  = wb_we;
                slv_b.sel = wb_sel;
                slv_b.dat = wb_dat_w;
                beat_q.push_back(slv_b);
                bidx++;
                wcnt = -1;
            end else begin
                wb_ack = 1'b0;
                wb_err = 1'b0;
                wcnt--;
            end
        end
    end

    // Read-return and activity monitor.
    always @(negedge clk) begin
        if (rvalid) begin
            mon_r.data = rdata;
            mon_r.id   = rid;
            mon_r.cyc  = cyc_cnt;
            rv_q.push_back(mon_r);
        end
        if (write_outstanding) wo_cycles++;
        if (wb_we) we_cycles++;
        if (wb_cyc) cyc_cycles++;
    end

    task automatic clear_logs;
        beat_q.delete();
        rv_q.delete();
        wo_cycles = 0;
        we_cycles = 0;
        cyc_cycles = 0;
    endtask

    task automatic issue(input logic r, input logic [29:0] a,
                         input logic [4:0] l, input logic [3:0] be,
                         input logic [31:0] wd, input logic [1:0] i,
                         output int lat);
        @(negedge clk);
        request = 1'b1;
        rnw = r;
        addr = a;
        rlen = l;
        wbe = be;
        wdata = wd;
        id = i;
        rmw = 1'($urandom_range(0, 1));
        lat = 0;
        #1;
        while (!ack && lat < 100) begin
            @(negedge clk);
            #1;
            lat++;
        end
        if (!ack) begin
            lat = -1;
        end else begin
            @(posedge clk);
            #1;
        end
        request = 1'b0;
        addr = 30'($urandom);
        rlen = 5'($urandom);
        wbe = 4'($urandom);
        wdata = $urandom;
        id = 2'($urandom);
    endtask

    task automatic wait_idle(output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (wb_cyc && n < 400) begin
            @(negedge clk);
            n++;
        end
        ok = !wb_cyc;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({wb_cyc, wb_stb, wb_we, wb_cti, ack, rvalid, write_outstanding} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got cyc=%b stb=%b we=%b cti=%b ack=%b rvalid=%b wo=%b, want all 0",
                     wb_cyc, wb_stb, wb_we, wb_cti, ack, rvalid, write_outstanding);
        end
        n_checks++;
        if ({wb_adr, wb_sel, wb_dat_w} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_wb_data: got adr=%h sel=%h dat=%h, want 0", wb_adr, wb_sel, wb_dat_w);
        end
        n_checks++;
        if ({rdata, rid, inv, inv_addr, wb_bte} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_rd: got rdata=%h rid=%h inv=%b inv_addr=%h bte=%h, want 0",
                     rdata, rid, inv, inv_addr, wb_bte);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_read;
        int lat;
        bit ok;
        slv_wmin = 0; slv_wmax = 0; slv_noise = 1'b0;
        slv_fix = 1'b1; slv_fix_data = 32'hDEADBEEF;
        clear_logs();
        issue(1'b1, 30'h100, 5'd0, 4'h0, 32'h0, 2'd2, lat);
        n_checks++;
        if (lat !== 0) begin
            n_fail++;
            $display("FAIL single_ack_lat: got %0d, want 0", lat);
        end
        n_checks++;
        if (wb_cyc !== 1'b1 || wb_adr !== 30'h100 || wb_cti !== exp_rd_cti(0, 0) || wb_we !== 1'b0) begin
            n_fail++;
            $display("FAIL single_first_beat: got cyc=%b adr=%h cti=%b we=%b, want 1 100 %b 0",
                     wb_cyc, wb_adr, wb_cti, wb_we, exp_rd_cti(0, 0));
        end
        wait_idle(ok);
        slv_fix = 1'b0;
        n_checks++;
        if (!ok || rv_q.size() != 1) begin
            n_fail++;
            $display("FAIL single_count: got idle=%b rvalids=%0d, want 1 1", ok, rv_q.size());
        end else begin
            n_checks++;
            if (rv_q[0].data !== 32'hDEADBEEF || rv_q[0].id !== 2'd2) begin
                n_fail++;
                $display("FAIL single_data: got %h id %0d, want deadbeef id 2", rv_q[0].data, rv_q[0].id);
            end
        end
    endtask

    task automatic test_burst_wrap;
        int lat;
        bit ok;
        logic [1:0] i;
        logic [29:0] ea;
        i = 2'($urandom);
        slv_wmin = 0; slv_wmax = 0; slv_noise = 1'b0;
        clear_logs();
        issue(1'b1, 30'h3FFFFFFE, 5'd3, 4'h0, 32'h0, i, lat);
        wait_idle(ok);
        n_checks++;
        if (lat !== 0 || !ok || beat_q.size() != 4 || rv_q.size() != 4 || cyc_cycles != 4) begin
            n_fail++;
            $display("FAIL burst_shape: got lat=%0d idle=%b beats=%0d rvalids=%0d cyc_cycles=%0d, want 0 1 4 4 4",
                     lat, ok, beat_q.size(), rv_q.size(), cyc_cycles);
        end else begin
            for (int k = 0; k < 4; k++) begin
                ea = 30'h3FFFFFFE + 30'(k);
                n_checks++;
                if (beat_q[k].adr !== ea || beat_q[k].cti !== exp_rd_cti(k, 3) || beat_q[k].sel !== 4'hF) begin
                    n_fail++;
                    $display("FAIL burst_beat%0d: got adr=%h cti=%b sel=%h, want %h %b f",
                             k, beat_q[k].adr, beat_q[k].cti, beat_q[k].sel, ea, exp_rd_cti(k, 3));
                end
                n_checks++;
                if (rv_q[k].data !== mem_word(ea) || rv_q[k].id !== i || rv_q[k].cyc != rv_q[0].cyc + k) begin
                    n_fail++;
                    $display("FAIL burst_rv%0d: got %h id %0d cyc %0d, want %h id %0d cyc %0d",
                             k, rv_q[k].data, rv_q[k].id, rv_q[k].cyc, mem_word(ea), i, rv_q[0].cyc + k);
                end
            end
        end
    endtask

    task automatic test_write;
        int lat;
        bit ok;
        slv_wmin = 3; slv_wmax = 3; slv_noise = 1'b0;
        clear_logs();
        issue(1'b0, 30'h2A5, 5'd9, 4'b0101, 32'h12345678, 2'd1, lat);
        wait_idle(ok);
        n_checks++;
        if (lat !== 0 || !ok || beat_q.size() != 1 || rv_q.size() != 0) begin
            n_fail++;
            $display("FAIL write_shape: got lat=%0d idle=%b beats=%0d rvalids=%0d, want 0 1 1 0",
                     lat, ok, beat_q.size(), rv_q.size());
        end else begin
            n_checks++;
            if (beat_q[0] !== {30'h2A5, (BURST_EN ? 3'b111 : 3'b000), 1'b1, 4'b0101, 32'h12345678}) begin
                n_fail++;
                $display("FAIL write_beat: got adr=%h cti=%b we=%b sel=%b dat=%h, want 2a5 111 1 0101 12345678",
                         beat_q[0].adr, beat_q[0].cti, beat_q[0].we, beat_q[0].sel, beat_q[0].dat);
            end
        end
        n_checks++;
        if (wo_cycles != 4 || we_cycles != 4) begin
            n_fail++;
            $display("FAIL write_outstanding_len: got wo=%0d we=%0d cycles, want 4 4", wo_cycles, we_cycles);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        int k;
        int l1;
        bit ok;
        logic [29:0] a1;
        logic [29:0] a2;
        slv_wmin = 0; slv_wmax = 0; slv_noise = 1'b0;
        l1 = $urandom_range(1, 3);
        a1 = 30'($urandom);
        a2 = 30'($urandom);
        clear_logs();
        issue(1'b1, a1, 5'(l1), 4'h0, 32'h0, 2'd1, lat);
        request = 1'b1; rnw = 1'b1; addr = a2; rlen = 5'd0; id = 2'd3;
        k = 0;
        @(negedge clk);
        #1;
        while (!ack && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        n_checks++;
        if (lat !== 0 || k != l1 + 1 || wb_cyc !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ack_cycle: got lat=%0d wait=%0d cyc=%b, want 0 %0d 0", lat, k, wb_cyc, l1 + 1);
        end
        @(posedge clk);
        #1;
        request = 1'b0;
        wait_idle(ok);
        n_checks++;
        if (!ok || rv_q.size() != l1 + 2) begin
            n_fail++;
            $display("FAIL b2b_count: got idle=%b rvalids=%0d, want 1 %0d", ok, rv_q.size(), l1 + 2);
        end else begin
            n_checks++;
            if (rv_q[l1 + 1].data !== mem_word(a2) || rv_q[l1 + 1].id !== 2'd3
                || rv_q[l1].data !== mem_word(a1 + 30'(l1)) || rv_q[l1].id !== 2'd1) begin
                n_fail++;
                $display("FAIL b2b_data: got %h/%0d %h/%0d, want %h/1 %h/3",
                         rv_q[l1].data, rv_q[l1].id, rv_q[l1 + 1].data, rv_q[l1 + 1].id,
                         mem_word(a1 + 30'(l1)), mem_word(a2));
            end
        end
    endtask

    task automatic test_error;
        int lat;
        bit ok;
        logic [29:0] a;
        a = 30'($urandom);
        slv_wmin = 0; slv_wmax = 2; slv_noise = 1'b0; slv_err_beat = 1;
        clear_logs();
        issue(1'b1, a, 5'd1, 4'h0, 32'h0, 2'd0, lat);
        wait_idle(ok);
        slv_err_beat = -1;
        n_checks++;
        if (!ok || rv_q.size() != 2 || beat_q.size() != 2 || write_outstanding !== 1'b0) begin
            n_fail++;
            $display("FAIL err_shape: got idle=%b rvalids=%0d beats=%0d wo=%b, want 1 2 2 0",
                     ok, rv_q.size(), beat_q.size(), write_outstanding);
        end else begin
            n_checks++;
            if (rv_q[0].data !== mem_word(a) || rv_q[1].data !== 32'd0
                || beat_q[1].adr !== a + 30'd1 || beat_q[1].cti !== exp_rd_cti(1, 1)) begin
                n_fail++;
                $display("FAIL err_data: got %h %h adr=%h cti=%b, want %h 0 %h %b",
                         rv_q[0].data, rv_q[1].data, beat_q[1].adr, beat_q[1].cti,
                         mem_word(a), a + 30'd1, exp_rd_cti(1, 1));
            end
        end
        issue(1'b1, a, 5'd0, 4'h0, 32'h0, 2'd0, lat);
        wait_idle(ok);
        n_checks++;
        if (lat !== 0 || !ok) begin
            n_fail++;
            $display("FAIL err_recover: got lat=%0d idle=%b, want 0 1", lat, ok);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        int n;
        int held;
        bit ok;
        logic [29:0] a;
        a = 30'($urandom);
        slv_wmin = 0; slv_wmax = 0; slv_noise = 1'b0;
        clear_logs();
        issue(1'b1, a, 5'd7, 4'h0, 32'h0, 2'd2, lat);
        n = 0;
        while (rv_q.size() < 2 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (n >= 50 || wb_cyc !== 1'b0 || wb_stb !== 1'b0 || rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_drop: got wait=%0d cyc=%b stb=%b rvalid=%b, want <50 0 0 0",
                     n, wb_cyc, wb_stb, rvalid);
        end
        held = rv_q.size();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (held != 2 || rv_q.size() != 2 || wb_cyc !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_discard: got rvalids=%0d then %0d cyc=%b, want 2 2 0",
                     held, rv_q.size(), wb_cyc);
        end else begin
            n_checks++;
            if (rv_q[1].data !== mem_word(a + 30'd1) || rv_q[1].id !== 2'd2) begin
                n_fail++;
                $display("FAIL rstmid_data: got %h id %0d, want %h id 2",
                         rv_q[1].data, rv_q[1].id, mem_word(a + 30'd1));
            end
        end
        clear_logs();
        issue(1'b1, a, 5'd2, 4'h0, 32'h0, 2'd1, lat);
        wait_idle(ok);
        n_checks++;
        if (lat !== 0 || !ok || rv_q.size() != 3) begin
            n_fail++;
            $display("FAIL rstmid_after: got lat=%0d idle=%b rvalids=%0d, want 0 1 3", lat, ok, rv_q.size());
        end else begin
            n_checks++;
            if (rv_q[2].data !== mem_word(a + 30'd2) || rv_q[2].id !== 2'd1) begin
                n_fail++;
                $display("FAIL rstmid_after_data: got %h id %0d, want %h id 1",
                         rv_q[2].data, rv_q[2].id, mem_word(a + 30'd2));
            end
        end
    endtask

    task automatic test_random;
        int lat;
        int nb;
        bit ok;
        logic r;
        logic [29:0] a;
        logic [4:0] l;
        logic [3:0] be;
        logic [31:0] wd;
        logic [1:0] i;
        beat_t e;
        slv_wmin = 0; slv_wmax = 2; slv_noise = 1'b1;
        for (int t = 0; t < 25; t++) begin
            r  = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 3) == 0) ? 30'h3FFFFFF0 + 30'($urandom_range(0, 15)) : 30'($urandom);
            l  = 5'($urandom);
            be = 4'($urandom);
            wd = $urandom;
            i  = 2'($urandom);
            clear_logs();
            issue(r, a, l, be, wd, i, lat);
            wait_idle(ok);
            nb = r ? int'(l) + 1 : 1;
            n_checks++;
            if (lat < 0 || !ok || beat_q.size() != nb || rv_q.size() != (r ? nb : 0)) begin
                n_fail++;
                $display("FAIL rand%0d_shape: got lat=%0d idle=%b beats=%0d rvalids=%0d, want >=0 1 %0d %0d",
                         t, lat, ok, beat_q.size(), rv_q.size(), nb, r ? nb : 0);
                continue;
            end
            for (int k = 0; k < nb; k++) begin
                e.adr = r ? a + 30'(k) : a;
                e.cti = r ? exp_rd_cti(k, int'(l)) : (BURST_EN ? 3'b111 : 3'b000);
                e.we  = !r;
                e.sel = r ? 4'hF : be;
                e.dat = wd;
                n_checks++;
                if (beat_q[k] !== e) begin
                    n_fail++;
                    $display("FAIL rand%0d_beat%0d: got %h, want %h", t, k, beat_q[k], e);
                end
                if (r) begin
                    n_checks++;
                    if (rv_q[k].data !== mem_word(e.adr) || rv_q[k].id !== i) begin
                        n_fail++;
                        $display("FAIL rand%0d_rv%0d: got %h id %0d, want %h id %0d",
                                 t, k, rv_q[k].data, rv_q[k].id, mem_word(e.adr), i);
                    end
                end
            end
        end
        slv_noise = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        request = 1'b0;
        rnw = 1'b0;
        rmw = 1'b0;
        addr = 30'd0;
        rlen = 5'd0;
        wbe = 4'd0;
        wdata = 32'd0;
        id = 2'd0;
        wb_ack = 1'b0;
        wb_err = 1'b0;
        wb_dat_r = 32'd0;
        test_reset();
        test_single_read();
        test_burst_wrap();
        test_write();
        test_back_to_back();
        test_error();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wishbone_bridge.md
# mem_wishbone_bridge

Converts requests on the memory-side `mem_interface` (bridge is the `mem_slave` end) into Wishbone B4 master cycles on a `master_wishbone_interface_output`/`master_wishbone_interface_input` pair. Sits directly downstream of the core's memory arbiter and upstream of the external Wishbone bus. Handles one request at a time: multi-word reads as incrementing bursts, writes as single beats. Returns read words with the request's id.

## Interface
- `BURST_EN`, 1, 1: incrementing-burst cycle tags (`cti`=3'b010, last 3'b111); 0: classic cycles (`cti`=3'b000 on every beat)
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `request`  in  1  memory request valid
- `addr`  in  30  word address, bits [31:2]
- `rlen`  in  5  read length minus one (0 = 1 word, 31 = 32 words)
- `rnw`  in  1  1 read, 0 write
- `rmw`  in  1  accepted, ignored
- `wbe`  in  4  write byte enables
- `wdata`  in  32  write data
- `id`  in  2  request id
- `ack`  out  1  request accepted
- `rvalid`  out  1  read word valid
- `rdata`  out  32  read word
- `rid`  out  2  id of read word
- `inv`  out  1  constant 0
- `inv_addr`  out  30  constant 0
- `write_outstanding`  out  1  write in flight
- `wb_adr`  out  30  Wishbone word address
- `wb_dat_w`  out  32  write data
- `wb_sel`  out  4  byte selects
- `wb_cyc`, `wb_stb`, `wb_we`  out  1 each  cycle, strobe, write enable
- `wb_cti`  out  3  cycle type identifier
- `wb_bte`  out  2  constant 2'b00 (linear)
- `wb_dat_r`  in  32  read data
- `wb_ack`, `wb_err`  in  1 each  beat termination

## Operation
- States: IDLE, READ, WRITE.
- IDLE: `ack` = `request` (combinational, IDLE only). On `request`: latch `addr`, `rlen`, `wbe`, `wdata`, `id`. Next state READ if `rnw`, else WRITE. Beat counter loads `rlen`.
- READ: `wb_cyc`=`wb_stb`=1, `wb_we`=0, `wb_sel`=4'hF. Beat termination = `wb_ack | wb_err` (both high counts as one beat).
  - Each termination: capture `wb_dat_r` into `rdata`, latched id into `rid`, pulse `rvalid`.
  - Same termination: `wb_adr` increments by 1, wrapping at 2^30. Counter decrements.
  - Termination with counter 0: cycle ends, return to IDLE.
- `wb_cti` when `BURST_EN`=1: 3'b010 while counter > 0, 3'b111 when counter = 0. Single-word read is therefore 3'b111 only.
- WRITE: one beat. `wb_cyc`=`wb_stb`=`wb_we`=1, `wb_sel`=`wbe`, `wb_dat_w`=`wdata`, `wb_cti`=3'b111 (3'b000 if `BURST_EN`=0). `rlen` ignored. Termination returns to IDLE; no `rvalid`.
- `wb_err` is not reported upstream. An errored read beat still returns `wb_dat_r` with `rvalid`.
- `write_outstanding` = 1 exactly while in WRITE.
- Outside READ/WRITE: `wb_cyc`, `wb_stb`, `wb_we` are 0. `wb_adr`, `wb_sel`, `wb_dat_w` hold their last values.

## Timing
- Reset (async assert, sync release): state IDLE; every output 0 (`wb_cyc`, `wb_stb`, `wb_we`, `wb_adr`, `wb_sel`, `wb_dat_w`, `wb_cti`, `rvalid`, `rdata`, `rid`, `write_outstanding`, `ack` with request low).
- Request accepted at edge N: `wb_cyc`/`wb_stb` high from cycle N+1. All Wishbone outputs are registered.
- Read beat terminated at edge M: `rvalid` high for cycle M+1 only, with `rdata`/`rid`. Sustained throughput is 1 word/cycle when the slave holds `wb_ack` high.
- Final termination at edge M: `wb_cyc`=0 in cycle M+1. IDLE in M+1, so the next `ack` can occur in M+1.
- `wb_ack` outside an active cycle is ignored.
- Reset mid-burst: `wb_cyc` drops immediately. Pending words are discarded; no `rvalid`.

## Test plan
- Single read: `addr`=30'h100, `rlen`=0, `id`=2 -> `ack` in the request cycle; `wb_adr`=30'h100, `wb_cti`=3'b111 next cycle. Slave acks with 32'hDEADBEEF -> one `rvalid` pulse, `rdata`=32'hDEADBEEF, `rid`=2.
- Burst read: `rlen`=3, `addr`=30'h3FFFFFFE, slave acks every cycle -> `wb_adr` sequence 3FFFFFFE, 3FFFFFFF, 0, 1; `cti` 010, 010, 010, 111; four consecutive `rvalid` pulses; `wb_cyc` low after the 4th beat.
- Write: `rnw`=0, `wbe`=4'b0101, `wdata`=32'h12345678, slave waits 3 cycles -> `wb_we`=1, `wb_sel`=4'b0101, `write_outstanding` high for 4 cycles; no `rvalid`.
- Back-to-back: second request held high during the first -> second `ack` occurs the cycle after the first's final beat termination.
- Error: `rlen`=1, second beat terminated by `wb_err` with `wb_dat_r`=0 -> two `rvalid` pulses; bridge returns to IDLE.
- Reset mid-burst: `rlen`=7, assert `rst` after beat 2 -> `wb_cyc`=0 immediately; no further `rvalid`; a new request after release is served normally.
